// File: rtl/dl1_write_buffer_pkg.sv
// Shared types and sizing for the DL1 word-granular store buffer.
// Entry layout, drain FSM states and default geometry live here.
package dl1_write_buffer_pkg;

    localparam int WB_DEPTH    = 4;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int WADDR_WIDTH = ADDR_WIDTH - 2;

    typedef struct packed {
        logic                   valid;
        logic [WADDR_WIDTH-1:0] word_addr;
        logic [DATA_WIDTH-1:0]  data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_REQ  = 2'd1,
        D_DONE = 2'd2
    } wb_drain_state_t;

endpackage

// File: rtl/dl1_write_buffer_if.sv
// Store/lookup/drain/L2 signal bundle between the DL1 controller, L2 and the write buffer.
// master = controller + L2 side, slave = write buffer.
interface dl1_write_buffer_if;
    import dl1_write_buffer_pkg::*;

    logic                  wb_write;
    logic [ADDR_WIDTH-1:0] wb_waddr;
    logic [DATA_WIDTH-1:0] wb_wdata;
    logic [ADDR_WIDTH-1:0] wb_lookup_addr;
    logic                  wb_hit;
    logic [DATA_WIDTH-1:0] wb_hit_data;
    logic                  wb_full;
    logic                  wb_empty;
    logic                  wb_overflow;
    logic                  wb_underflow;
    logic                  wb_trigger;
    logic                  wb_done;
    logic                  wb_read;
    logic                  l2_wr_req;
    logic [ADDR_WIDTH-1:0] l2_wr_addr;
    logic [DATA_WIDTH-1:0] l2_wr_data;
    logic                  l2_wr_ack;

    modport master (
        output wb_write, wb_waddr, wb_wdata, wb_lookup_addr,
        output wb_trigger, wb_read, l2_wr_ack,
        input  wb_hit, wb_hit_data, wb_full, wb_empty,
        input  wb_overflow, wb_underflow, wb_done,
        input  l2_wr_req, l2_wr_addr, l2_wr_data
    );

    modport slave (
        input  wb_write, wb_waddr, wb_wdata, wb_lookup_addr,
        input  wb_trigger, wb_read, l2_wr_ack,
        output wb_hit, wb_hit_data, wb_full, wb_empty,
        output wb_overflow, wb_underflow, wb_done,
        output l2_wr_req, l2_wr_addr, l2_wr_data
    );

endinterface

// File: rtl/dl1_write_buffer_cam_match.sv
// Word-address CAM over the buffer entries; returns the youngest unlocked match as one-hot.
// Purely combinational, no backpressure.
module dl1_write_buffer_cam_match
    import dl1_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t              entries [DEPTH],
    input  logic [WADDR_WIDTH-1:0] word_addr,
    input  logic [PTR_W-1:0]       rd_ptr,
    input  logic [DEPTH-1:0]       lock_mask,
    output logic [DEPTH-1:0]       match_oh,
    output logic                   hit
);

    logic [DEPTH-1:0] raw_match;
    logic [PTR_W-1:0] idx;
    logic             unused_data;

    always_comb begin
        raw_match   = '0;
        unused_data = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            raw_match[i] = entries[i].valid && !lock_mask[i] &&
                           (entries[i].word_addr == word_addr);
            unused_data  = unused_data ^ (^entries[i].data);
        end
    end

    // Walk from the head (oldest) towards wr_ptr; the last match seen is the youngest.
    always_comb begin
        match_oh = '0;
        idx      = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (raw_match[idx]) begin
                match_oh      = '0;
                match_oh[idx] = 1'b1;
            end
        end
    end

    assign hit = |raw_match;

endmodule

// File: rtl/dl1_write_buffer.sv
// Coalescing word store buffer between DL1 and L2 with load-hit lookup and head drain FSM.
// Trigger->l2_wr_req 1 cycle, ack->wb_done 1 cycle; stores to a full buffer are dropped with wb_overflow.
module dl1_write_buffer
    import dl1_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic               clk_l1,
    input  logic               rst,
    dl1_write_buffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t              entries_q [DEPTH];
    wb_entry_t              entries_d [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    wb_drain_state_t        state_q;
    logic                   l2_req_q;
    logic                   done_q;
    logic [WADDR_WIDTH-1:0] l2_waddr_q;
    logic [DATA_WIDTH-1:0]  l2_data_q;

    logic                   full, empty;
    logic                   push, pop;
    logic [DEPTH-1:0]       lock_mask;
    logic [DEPTH-1:0]       lu_oh, st_oh;
    logic                   lu_hit, st_hit;
    logic [DATA_WIDTH-1:0]  lu_hit_data;
    logic                   unused_addr_lsbs;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // The head being drained must not absorb new stores: L2 already has its old data.
    assign lock_mask = (state_q != D_IDLE) ? (DEPTH'(1) << rd_ptr_q) : '0;

    dl1_write_buffer_cam_match #(.DEPTH(DEPTH)) u_lookup_cam (
        .entries   (entries_q),
        .word_addr (bus.wb_lookup_addr[ADDR_WIDTH-1:2]),
        .rd_ptr    (rd_ptr_q),
        .lock_mask ('0),
        .match_oh  (lu_oh),
        .hit       (lu_hit)
    );

    dl1_write_buffer_cam_match #(.DEPTH(DEPTH)) u_store_cam (
        .entries   (entries_q),
        .word_addr (bus.wb_waddr[ADDR_WIDTH-1:2]),
        .rd_ptr    (rd_ptr_q),
        .lock_mask (lock_mask),
        .match_oh  (st_oh),
        .hit       (st_hit)
    );

    always_comb begin
        lu_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lu_oh[i]) begin
                lu_hit_data = lu_hit_data | entries_q[i].data;
            end
        end
    end

    always_comb begin
        entries_d   = entries_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pop         = bus.wb_read && !empty;
        push        = bus.wb_write && !st_hit && (!full || pop);
        overflow_d  = bus.wb_write && !st_hit && full && !pop;
        underflow_d = bus.wb_read && empty;

        if (bus.wb_write && st_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_oh[i]) begin
                    entries_d[i].data = bus.wb_wdata;
                end
            end
        end

        if (pop) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + 1'b1;
        end

        // Applied after the pop so a full-buffer push into the freed slot keeps its valid bit.
        if (push) begin
            entries_d[wr_ptr_q].valid     = 1'b1;
            entries_d[wr_ptr_q].word_addr = bus.wb_waddr[ADDR_WIDTH-1:2];
            entries_d[wr_ptr_q].data      = bus.wb_wdata;
            wr_ptr_d                      = wr_ptr_q + 1'b1;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_l1) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_l1) begin
        if (rst) begin
            state_q    <= D_IDLE;
            l2_req_q   <= 1'b0;
            done_q     <= 1'b0;
            l2_waddr_q <= '0;
            l2_data_q  <= '0;
        end else begin
            unique case (state_q)
                D_IDLE: begin
                    if (bus.wb_trigger && !empty) begin
                        state_q    <= D_REQ;
                        l2_req_q   <= 1'b1;
                        l2_waddr_q <= entries_q[rd_ptr_q].word_addr;
                        l2_data_q  <= entries_q[rd_ptr_q].data;
                    end
                end
                D_REQ: begin
                    if (bus.l2_wr_ack) begin
                        state_q  <= D_DONE;
                        l2_req_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                D_DONE: begin
                    if (bus.wb_read) begin
                        state_q <= D_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= D_IDLE;
                    l2_req_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wb_hit       = lu_hit;
    assign bus.wb_hit_data  = lu_hit_data;
    assign bus.wb_full      = full;
    assign bus.wb_empty     = empty;
    assign bus.wb_overflow  = overflow_q;
    assign bus.wb_underflow = underflow_q;
    assign bus.wb_done      = done_q;
    assign bus.l2_wr_req    = l2_req_q;
    assign bus.l2_wr_addr   = {l2_waddr_q, 2'b00};
    assign bus.l2_wr_data   = l2_data_q;

    assign unused_addr_lsbs = ^{bus.wb_waddr[1:0], bus.wb_lookup_addr[1:0]};

endmodule

// File: tb/tb_dl1_write_buffer.sv
// Directed scoreboard bench for dl1_write_buffer: stimulus queues expectations, a negedge monitor checks them.
module tb_dl1_write_buffer;
    import dl1_write_buffer_pkg::*;

    logic clk_l1 = 1'b0;
    logic rst    = 1'b1;

    dl1_write_buffer_if bus ();

    dl1_write_buffer dut (
        .clk_l1 (clk_l1),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_l1 = ~clk_l1;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always @(posedge clk_l1) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } l2_exp_t;

    typedef struct packed {
        logic        chk_lu;
        logic        hit;
        logic [31:0] data;
        logic [3:0]  status;   // {full, empty, done, req}
    } probe_t;

    l2_exp_t l2_q[$];
    probe_t  probe_q[$];
    string   probe_name_q[$];
    int      ovf_q[$];
    int      unf_q[$];

    logic probe_vld = 1'b0;
    int   exp_cnt   = 0;
    logic exp_done  = 1'b0;
    logic exp_req   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: unexpected DUT event at cycle %0d", name, cyc);
    endtask

    // Monitor
    l2_exp_t l2_cur;
    logic    req_prev = 1'b0;
    probe_t  p;
    string   pn;
    int      ec;

    always @(negedge clk_l1) begin
        if (bus.l2_wr_req === 1'b1 && req_prev !== 1'b1) begin
            if (l2_q.size() == 0) fail("l2_unexpected_req");
            else begin
                l2_cur = l2_q.pop_front();
                check("l2_req", {bus.l2_wr_addr, bus.l2_wr_data}, l2_cur);
            end
        end else if (bus.l2_wr_req === 1'b1) begin
            check("l2_hold", {bus.l2_wr_addr, bus.l2_wr_data}, l2_cur);
        end
        req_prev = bus.l2_wr_req;

        if (bus.wb_overflow === 1'b1) begin
            if (ovf_q.size() == 0) fail("ovf_unexpected");
            else begin ec = ovf_q.pop_front(); check("ovf_cycle", cyc, ec); end
        end
        if (bus.wb_underflow === 1'b1) begin
            if (unf_q.size() == 0) fail("unf_unexpected");
            else begin ec = unf_q.pop_front(); check("unf_cycle", cyc, ec); end
        end

        if (probe_vld) begin
            p  = probe_q.pop_front();
            pn = probe_name_q.pop_front();
            if (p.chk_lu) check({pn, ".lookup"}, {bus.wb_hit, bus.wb_hit_data}, {p.hit, p.data});
            check({pn, ".status"}, {bus.wb_full, bus.wb_empty, bus.wb_done, bus.l2_wr_req}, p.status);
        end
    end

    // Stimulus helpers
    task automatic idle_inputs();
        bus.wb_write   = 1'b0;
        bus.wb_read    = 1'b0;
        bus.wb_trigger = 1'b0;
        bus.l2_wr_ack  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_l1);
        #1;
        idle_inputs();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input int cnt_after, input bit ovf);
        bus.wb_write = 1'b1;
        bus.wb_waddr = a;
        bus.wb_wdata = d;
        if (ovf) ovf_q.push_back(cyc + 1);
        step();
        exp_cnt = cnt_after;
    endtask

    task automatic rd(input int cnt_after, input bit unf);
        bus.wb_read = 1'b1;
        if (unf) unf_q.push_back(cyc + 1);
        step();
        exp_cnt = cnt_after;
    endtask

    task automatic probe(input string name, input logic [31:0] la, input bit chk,
                         input bit hit, input logic [31:0] d);
        probe_t e;
        e.chk_lu = chk;
        e.hit    = hit;
        e.data   = d;
        e.status = {exp_cnt == 4, exp_cnt == 0, exp_done, exp_req};
        bus.wb_lookup_addr = la;
        probe_q.push_back(e);
        probe_name_q.push_back(name);
        probe_vld = 1'b1;
        step();
        probe_vld = 1'b0;
    endtask

    task automatic drain_start(input logic [31:0] a, input logic [31:0] d);
        l2_q.push_back({a, d});
        bus.wb_trigger = 1'b1;
        step();
        exp_req = 1'b1;
    endtask

    task automatic drain_finish(input int hold, input int cnt_after);
        for (int i = 0; i < hold; i++) probe("drain_req", 32'h0, 1'b0, 1'b0, 32'h0);
        bus.l2_wr_ack = 1'b1;
        step();
        exp_req  = 1'b0;
        exp_done = 1'b1;
        probe("drain_done", 32'h0, 1'b0, 1'b0, 32'h0);
        rd(cnt_after, 1'b0);
        exp_done = 1'b0;
        probe("drain_popped", 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        idle_inputs();
        bus.wb_waddr       = '0;
        bus.wb_wdata       = '0;
        bus.wb_lookup_addr = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        probe("reset", 32'h100, 1'b1, 1'b0, 32'h0);

        // Basic push and lookup
        store(32'h100, 32'hAAAA0001, 1, 1'b0);
        store(32'h104, 32'hBBBB0002, 2, 1'b0);
        probe("t1_hit",  32'h100, 1'b1, 1'b1, 32'hAAAA0001);
        probe("t1_lsb",  32'h102, 1'b1, 1'b1, 32'hAAAA0001);
        probe("t1_miss", 32'h108, 1'b1, 1'b0, 32'h0);

        // Coalesce, fill, overflow, coalesce while full
        store(32'h104, 32'hCCCC0003, 2, 1'b0);
        probe("t2_coal", 32'h104, 1'b1, 1'b1, 32'hCCCC0003);
        store(32'h108, 32'h11110004, 3, 1'b0);
        store(32'h10C, 32'h22220005, 4, 1'b0);
        probe("t2_full", 32'h10C, 1'b1, 1'b1, 32'h22220005);
        store(32'h200, 32'hDEAD0000, 4, 1'b1);
        probe("t2_ovf_drop", 32'h200, 1'b1, 1'b0, 32'h0);
        probe("t2_ovf_keep", 32'h108, 1'b1, 1'b1, 32'h11110004);
        store(32'h108, 32'h33330006, 4, 1'b0);
        probe("t2_coal_full", 32'h108, 1'b1, 1'b1, 32'h33330006);

        // Drain head with a 3-cycle L2 stall
        drain_start(32'h100, 32'hAAAA0001);
        drain_finish(3, 3);
        probe("t3_popped", 32'h100, 1'b1, 1'b0, 32'h0);

        // Store to the locked head during D_REQ pushes a new entry
        drain_start(32'h104, 32'hCCCC0003);
        store(32'h104, 32'h12345678, 4, 1'b0);
        probe("t4_young", 32'h104, 1'b1, 1'b1, 32'h12345678);
        drain_finish(1, 3);
        probe("t4_after", 32'h104, 1'b1, 1'b1, 32'h12345678);

        // Idle pop, refill to rd==wr==3, then full push+pop wraps wr_ptr
        rd(2, 1'b0);
        probe("t5_pop_idle", 32'h108, 1'b1, 1'b0, 32'h0);
        store(32'h300, 32'h44440007, 3, 1'b0);
        store(32'h304, 32'h55550008, 4, 1'b0);
        bus.wb_write = 1'b1;
        bus.wb_waddr = 32'h400;
        bus.wb_wdata = 32'h66660009;
        bus.wb_read  = 1'b1;
        step();
        exp_cnt = 4;
        probe("t5_swap_new", 32'h400, 1'b1, 1'b1, 32'h66660009);
        probe("t5_swap_old", 32'h10C, 1'b1, 1'b0, 32'h0);
        drain_start(32'h104, 32'h12345678);
        drain_finish(0, 3);
        drain_start(32'h300, 32'h44440007);
        drain_finish(0, 2);
        drain_start(32'h304, 32'h55550008);
        drain_finish(0, 1);
        drain_start(32'h400, 32'h66660009);
        drain_finish(0, 0);
        probe("t5_empty", 32'h400, 1'b1, 1'b0, 32'h0);

        // Trigger and pop while empty
        bus.wb_trigger = 1'b1;
        step();
        probe("t5_trig_empty", 32'h0, 1'b0, 1'b0, 32'h0);
        rd(0, 1'b1);
        probe("t5_unf", 32'h0, 1'b0, 1'b0, 32'h0);
        store(32'h500, 32'h77770010, 1, 1'b0);
        drain_start(32'h500, 32'h77770010);
        drain_finish(0, 0);

        // Reset in the middle of D_REQ
        store(32'h600, 32'h88880011, 1, 1'b0);
        drain_start(32'h600, 32'h88880011);
        probe("t6_req", 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        exp_cnt  = 0;
        exp_req  = 1'b0;
        exp_done = 1'b0;
        probe("t6_rst_600", 32'h600, 1'b1, 1'b0, 32'h0);
        probe("t6_rst_100", 32'h100, 1'b1, 1'b0, 32'h0);
        store(32'h700, 32'h99990012, 1, 1'b0);
        drain_start(32'h700, 32'h99990012);
        drain_finish(1, 0);

        step();
        step();
        check("l2_leftover",    l2_q.size(),    0);
        check("ovf_missing",    ovf_q.size(),   0);
        check("unf_missing",    unf_q.size(),   0);
        check("probe_leftover", probe_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
